// File: rtl/sseg_pkg.sv
// Shared types and constants for the thermometer seven-segment display controller.
// Segment codes are active-low, bit7 = dp, bits6:0 = g..a.
package sseg_pkg;

    localparam int BIN_W      = 10;
    localparam int NUM_DIGITS = 3;
    localparam int CONV_ITERS = BIN_W;
    localparam int MAX_SHOWN  = 999;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [7:0] SEG_LUT [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Reading handshake between the sensor capture logic (master) and the display controller (slave).
interface sseg_scan_ctrl_if;
    import sseg_pkg::*;

    logic             in_valid;
    logic [BIN_W-1:0] in_data;
    logic             in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface

// File: rtl/sseg_scan_ctrl_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one bit per clock, result valid with done.
// done and bcd present the final iteration combinationally so the caller commits on that edge.
module bin2bcd_seq
    import sseg_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    ovf
);

    localparam int SH_W = 4 * NUM_DIGITS + BIN_W;

    logic [SH_W-1:0] sh_q;
    logic [SH_W-1:0] sh_next;
    logic [3:0]      cnt_q;
    logic            run_q;
    logic            ovf_q;

    // NOTE: every always_comb output is assigned a default first so no latch can be inferred.
    always_comb begin
        logic [SH_W-1:0] adj;
        adj = sh_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (adj[BIN_W + 4*k +: 4] >= 4'd5)
                adj[BIN_W + 4*k +: 4] = adj[BIN_W + 4*k +: 4] + 4'd3;
        end
        sh_next = {adj[SH_W-2:0], 1'b0};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (start) begin
            sh_q  <= {{(4*NUM_DIGITS){1'b0}}, bin};
            cnt_q <= '0;
            run_q <= 1'b1;
            ovf_q <= (int'(bin) > MAX_SHOWN);
        end else if (run_q) begin
            sh_q  <= sh_next;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'(CONV_ITERS - 1))
                run_q <= 1'b0;
        end
    end

    assign done = run_q && (cnt_q == 4'(CONV_ITERS - 1));
    assign bcd  = sh_next[SH_W-1:BIN_W];
    assign ovf  = ovf_q;

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Thermometer display controller: accepts a reading, converts it to BCD and
// time-multiplexes three digits of the active-low six-digit module with a fixed decimal point.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int SCAN_DIV = 60000,
    parameter int DP_DIGIT = 1,
    parameter int BLANK_LZ = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sseg_scan_ctrl_if.slave      bus,
    output logic                 busy,
    output logic                 ovf,
    output logic [7:0]           sseg,
    output logic [5:0]           en
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    state_t                  state_q, state_d;
    logic                    start;
    logic                    conv_done;
    logic                    conv_ovf;
    logic [4*NUM_DIGITS-1:0] conv_bcd;

    bcd_t [NUM_DIGITS-1:0]   dig_q;
    logic                    ovf_q;
    logic [PW-1:0]           presc_q;
    logic [1:0]              idx_q;
    logic [1:0]              idx_next;
    logic                    tick;

    assign bus.in_ready = (state_q == ST_IDLE);
    assign busy         = (state_q == ST_CONV);
    assign start        = bus.in_valid && (state_q == ST_IDLE);
    assign ovf          = ovf_q;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bus.in_data),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.in_valid) state_d = ST_CONV;
            ST_CONV: if (conv_done)    state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // NOTE: the display registers are few and drive the pins, so they are reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dig_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CONV && conv_done) begin
                dig_q <= conv_bcd;
                ovf_q <= conv_ovf;
            end
        end
    end

    function automatic logic [7:0] digit_code(bcd_t [NUM_DIGITS-1:0] d, logic ov, logic [1:0] k);
        logic [7:0] code;
        logic       upper_zero;
        upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(k) && d[j] != 4'd0) upper_zero = 1'b0;
        end
        if (ov)
            code = SEG_DASH;
        else if (BLANK_LZ != 0 && int'(k) > DP_DIGIT && upper_zero)
            code = SEG_BLANK;
        else if (d[k] > 4'd9)
            code = SEG_BLANK;
        else
            code = SEG_LUT[d[k]];
        if (int'(k) == DP_DIGIT) code[7] = 1'b0;
        return code;
    endfunction

    assign tick     = (presc_q == PW'(SCAN_DIV - 1));
    assign idx_next = (idx_q == 2'(NUM_DIGITS - 1)) ? 2'd0 : idx_q + 2'd1;

    // Scan runs free of the FSM; a commit only changes what the next slot shows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            sseg    <= 8'b1100_0000;
            en      <= 6'b11_1111;
        end else if (tick) begin
            presc_q <= '0;
            idx_q   <= idx_next;
            sseg    <= digit_code(dig_q, ovf_q, idx_next);
            en      <= ~(6'b00_0001 << idx_next);
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

endmodule
